init_ca_encoder: RTL and testbench

Downstream consumer of the DRAM initialization sequencer's command handshake (`cmd_valid`/`cmd_type`/`cmd_data`/`cmd_ready`). It buffers init commands in a small FIFO and serializes them onto the DDR5 CA bus with chip-select framing and a programmable inter-command gap. It also owns the registered CKE output.

---
 rtl/init_cmd_pkg.sv | 33 +++
 rtl/init_cmd_fifo.sv | 45 ++++
 rtl/init_ca_encoder.sv | 140 ++++++++++++++
 tb/tb_init_ca_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/init_cmd_pkg.sv
// Purpose: shared command encodings and CA opcodes for the DRAM init path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package init_cmd_pkg;

  typedef enum logic [4:0] {
    CMD_PRE = 5'd1,
    CMD_ZQ  = 5'd2,
    CMD_MRW = 5'd3,
    CMD_CKE = 5'd4
  } cmd_type_t;

  localparam logic [13:0] CA_PREAB = 14'h041B;
  localparam logic [4:0]  MPC_OP    = 5'b01111;
  localparam logic [7:0]  MPC_ZQCAL = 8'h05;
  localparam logic [4:0]  MRW_OP    = 5'b00101;

  // One buffered command: {type, payload}
  localparam int CMD_W = 37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CYC1,
    ST_CYC2,
    ST_GAP
  } ca_state_t;

  // First CA cycle of a mode-register write: {0, MA, MRW opcode}
  function automatic logic [13:0] mrw_ca1(input logic [7:0] ma);
    return {1'b0, ma, MRW_OP};
  endfunction

endpackage

// File: rtl/init_cmd_fifo.sv
// Purpose: small synchronous command FIFO with wrap-bit pointers.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push ignored while full, pop ignored while empty; no pass-through.
module init_cmd_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; full/empty gating keeps the pointers consistent even if a caller misbehaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/init_ca_encoder.sv
// Purpose: buffers init commands and serializes them onto the DDR5 CA bus with CS framing, gap and CKE.
// Latency: push at edge E into empty/idle -> cs_n low from E+1 (1 cycle PRE/ZQ, 2 cycles MRW); CKE at E+1.
// Backpressure: cmd_ready = !fifo_full; a pop in the same cycle does not free a slot for that push.
module init_ca_encoder
  import init_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int T_GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [4:0]  cmd_type,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [13:0] ca,
  output logic        cs_n,
  output logic        cke,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic        err_bad_type
);

  localparam int GW = (T_GAP_CYCLES > 0) ? $clog2(T_GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(T_GAP_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  ca_state_t        state;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head_dat;
  logic [4:0]       head_type;
  logic [31:0]      head_data;
  logic             push;
  logic             pop;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       op_q;
  logic             is_mrw;
  logic             unused_hi;

  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign head_type = head_dat[36:32];
  assign head_data = head_dat[31:0];
  assign unused_hi = ^head_data[31:16];

  init_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({cmd_type, cmd_data}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  // Encoder FSM: pop/decode in IDLE, drive registered CA/CS, enforce gap, own CKE and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ca           <= '0;
      cs_n         <= 1'b1;
      cke          <= 1'b0;
      issue_cnt    <= '0;
      err_bad_type <= 1'b0;
      gap_cnt      <= '0;
      op_q         <= '0;
      is_mrw       <= 1'b0;
    end else begin
      // Deselected by default; only CA cycles override
      ca   <= '0;
      cs_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (head_type)
              CMD_PRE: begin
                state     <= ST_CYC1;
                ca        <= CA_PREAB;
                cs_n      <= 1'b0;
                is_mrw    <= 1'b0;
                issue_cnt <= issue_cnt + 16'd1;
              end
              CMD_ZQ: begin
                state     <= ST_CYC1;
                ca        <= {1'b0, MPC_ZQCAL, MPC_OP};
                cs_n      <= 1'b0;
                is_mrw    <= 1'b0;
                issue_cnt <= issue_cnt + 16'd1;
              end
              CMD_MRW: begin
                state  <= ST_CYC1;
                ca     <= mrw_ca1(head_data[7:0]);
                cs_n   <= 1'b0;
                op_q   <= head_data[15:8];
                is_mrw <= 1'b1;
              end
              CMD_CKE: cke <= head_data[0];
              default: err_bad_type <= 1'b1;
            endcase
          end
        end
        ST_CYC1: begin
          if (is_mrw) begin
            // Second MRW cycle is the last CA cycle, so it is counted here
            state     <= ST_CYC2;
            ca        <= {6'h00, op_q};
            cs_n      <= 1'b0;
            issue_cnt <= issue_cnt + 16'd1;
          end else if (T_GAP_CYCLES > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_ONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CYC2: begin
          if (T_GAP_CYCLES > 0) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_ONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + GAP_ONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_init_ca_encoder.sv
// Purpose: randomized and directed bench for init_ca_encoder against a timeline reference model.
// Latency: n/a.
// Backpressure: model decides acceptance from its own occupancy and checks cmd_ready.
module tb_init_ca_encoder;

  localparam int DEPTH = 4;
  localparam int TGAP  = 4;
  localparam int NMAX  = 8192;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [4:0]  cmd_type;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [13:0] ca;
  logic        cs_n;
  logic        cke;
  logic        busy;
  logic [15:0] issue_cnt;
  logic        err_bad_type;

  init_ca_encoder #(
    .FIFO_DEPTH   (DEPTH),
    .T_GAP_CYCLES (TGAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_type     (cmd_type),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .ca           (ca),
    .cs_n         (cs_n),
    .cke          (cke),
    .busy         (busy),
    .issue_cnt    (issue_cnt),
    .err_bad_type (err_bad_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: commands waiting, plus a timeline of expected CA activity per clock edge
  typedef struct {
    logic [4:0]  t;
    logic [31:0] d;
  } cmd_t;

  cmd_t        q[$];
  logic [13:0] exp_ca  [NMAX];
  bit          exp_act [NMAX];
  int          exp_inc [NMAX];
  int          n;
  int          next_free;   // earliest edge at which the encoder may pop again
  logic        cke_m;
  logic        err_m;
  logic [15:0] cnt_m;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic bit busy_m();
    return (q.size() > 0) || (n < next_free - 1);
  endfunction

  task automatic sched(input int e, input logic [13:0] v);
    exp_act[e] = 1'b1;
    exp_ca[e]  = v;
  endtask

  // Advance the model across clock edge n
  task automatic model_edge(input bit acc, input logic [4:0] t, input logic [31:0] d);
    cmd_t h;
    if (q.size() > 0 && n >= next_free) begin
      h = q.pop_front();
      case (h.t)
        5'd1: begin sched(n, 14'h041B); exp_inc[n]++; next_free = n + TGAP + 2; end
        5'd2: begin sched(n, 14'h00AF); exp_inc[n]++; next_free = n + TGAP + 2; end
        5'd3: begin
          sched(n, {1'b0, h.d[7:0], 5'b00101});
          sched(n + 1, {6'h00, h.d[15:8]});
          exp_inc[n + 1]++;
          next_free = n + TGAP + 3;
        end
        5'd4: begin cke_m = h.d[0]; next_free = n + 1; end
        default: begin err_m = 1'b1; next_free = n + 1; end
      endcase
    end
    if (acc) begin
      h.t = t;
      h.d = d;
      q.push_back(h);
    end
    cnt_m = cnt_m + 16'(exp_inc[n]);
  endtask

  task automatic check_outputs();
    chk("cs_n", cs_n, !exp_act[n]);
    chk("ca", ca, exp_act[n] ? exp_ca[n] : 14'h0);
    chk("cke", cke, cke_m);
    chk("busy", busy, busy_m());
    chk("issue_cnt", issue_cnt, cnt_m);
    chk("err_bad_type", err_bad_type, err_m);
  endtask

  // One clock: drive at negedge, step model on posedge, check at next negedge
  task automatic cycle(input logic v, input logic [4:0] t, input logic [31:0] d);
    bit acc;
    cmd_valid = v;
    cmd_type  = t;
    cmd_data  = d;
    chk("cmd_ready", cmd_ready, q.size() < DEPTH);
    acc = v && (q.size() < DEPTH);
    @(posedge clk);
    n++;
    model_edge(acc, t, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || busy_m()) && k < 300) begin
      cycle(1'b0, 5'd0, 32'd0);
      k++;
    end
    chk("drain_busy", busy, 1'b0);
  endtask

  function automatic logic [4:0] rand_type();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2)       return 5'd1;
    else if (r < 4)  return 5'd2;
    else if (r < 6)  return 5'd3;
    else if (r < 8)  return 5'd4;
    else if (r == 8) return 5'($urandom_range(5, 31));
    else             return 5'd0;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < NMAX; i++) begin
      exp_act[i] = 1'b0;
      exp_ca[i]  = '0;
      exp_inc[i] = 0;
    end
    n = 0; next_free = 0; cke_m = 1'b0; err_m = 1'b0; cnt_m = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_data = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    check_outputs();
    rst = 1'b0;

    // Single PRE, then MRW with MA=0x0D OP=0xA5
    cycle(1'b1, 5'd1, 32'd0);
    idle(8);
    cycle(1'b1, 5'd3, 32'h0000_A50D);
    idle(10);

    // Back-to-back PRE, ZQ, MRW, CKE(1)
    cycle(1'b1, 5'd1, 32'd0);
    cycle(1'b1, 5'd2, 32'd0);
    cycle(1'b1, 5'd3, $urandom);
    cycle(1'b1, 5'd4, 32'd1);
    drain();

    // Hold valid while the FSM is stalled in gaps: FIFO fills and cmd_ready drops
    for (int i = 0; i < 10; i++) cycle(1'b1, 5'(1 + (i % 3)), $urandom);
    drain();

    // Illegal type followed by PRE, then CKE back to 0
    cycle(1'b1, 5'd7, 32'd0);
    cycle(1'b1, 5'd1, 32'd0);
    cycle(1'b1, 5'd4, 32'd0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 4) cycle(1'b1, rand_type(), $urandom);
      else                          cycle(1'b0, 5'd0, $urandom);
    end
    drain();

    // Reset in CYC2 of an MRW with two PREs queued behind it
    cycle(1'b1, 5'd4, 32'd1);
    cycle(1'b1, 5'd3, $urandom);
    cycle(1'b1, 5'd1, 32'd0);
    cycle(1'b1, 5'd1, 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_ca", ca, 14'h0);
    chk("rst_cke", cke, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_issue_cnt", issue_cnt, 16'h0);
    chk("rst_err", err_bad_type, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    q.delete();
    for (int i = n; i < n + 8; i++) begin
      exp_act[i] = 1'b0;
      exp_inc[i] = 0;
    end
    next_free = 0; cke_m = 1'b0; err_m = 1'b0; cnt_m = '0;
    @(posedge clk);
    n++;
    @(negedge clk);
    rst = 1'b0;
    idle(12);

    // Recovery after reset
    cycle(1'b1, 5'd1, 32'd0);
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
